// File: rtl/vfb_axil_if.sv
// AXI4-Lite bundle between the frame-buffer sequencer (master) and the core's register slave.
interface vfb_axil_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/vfb_cfg_sequencer.sv
// AXI4-Lite master that configures/starts and stops/idle-polls a Video Frame Buffer Read core.
// Optional VFB_SWAP_EN: ping-pong PLANE1 rewrites on each frame_irq rising edge while running.
module vfb_cfg_sequencer #(
  parameter logic [31:0] BASE_ADDR   = 32'h43C0_0000,
  parameter int          PIXEL_BYTES = 4,
  parameter int          POLL_MAX    = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] cfg_width,
  input  logic [15:0] cfg_height,
  input  logic [15:0] cfg_stride,
  input  logic [5:0]  cfg_format,
  input  logic [31:0] cfg_plane0,
`ifdef VFB_SWAP_EN
  input  logic [31:0] cfg_plane1,
  input  logic        frame_irq,
`endif
  output logic        busy,
  output logic        running,
  output logic        done,
  output logic        err,
  vfb_axil_if.master  m_axi
);
  localparam int          PCW = $clog2(POLL_MAX + 1);
  localparam logic [31:0] PB  = 32'(PIXEL_BYTES);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WB, S_NEXT, S_POLL_AR, S_POLL_R, S_POLL_CHK, S_FIN} state_t;
  typedef enum logic [1:0] {M_START, M_STOP, M_SWAP} mode_t;

  state_t state, state_nxt;
  mode_t  mode;
  logic [2:0]     idx;
  logic           aw_done, w_done, aw_hs, w_hs, wr_leave;
  logic [PCW-1:0] poll_cnt;
  logic           rd_idle, rd_err, stop_pend;
  logic [15:0]    width_q, height_q;
  logic [31:0]    stride_q, plane0_q, swap_data, wr_data;
  logic [5:0]     format_q;
  logic [7:0]     wr_off;
  logic           launch_ok, sel_start, sel_stop, sel_swap, swap_go;
  logic           unused;

  assign unused = ^{m_axi.rdata[31:3], m_axi.rdata[1:0]};

  // Launch point: idle, or the done cycle so a latched stop follows immediately.
  assign launch_ok = (state == S_IDLE) || (state == S_FIN);
  assign sel_start = launch_ok && start;
  assign sel_stop  = launch_ok && !start && (stop || stop_pend);
  assign sel_swap  = launch_ok && !start && !(stop || stop_pend) && swap_go;

  assign aw_hs    = m_axi.awvalid && m_axi.awready;
  assign w_hs     = m_axi.wvalid && m_axi.wready;
  assign wr_leave = (aw_done || aw_hs) && (w_done || w_hs);

`ifdef VFB_SWAP_EN
  logic        irq_q, swap_pend, plane_sel;
  logic [31:0] plane1_q;
  assign swap_go   = swap_pend && running;
  assign swap_data = plane_sel ? plane1_q : plane0_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_q <= 1'b0; swap_pend <= 1'b0; plane_sel <= 1'b1; plane1_q <= '0;
    end else begin
      irq_q <= frame_irq;
      if (sel_swap || sel_start) swap_pend <= 1'b0;
      if (frame_irq && !irq_q && running) swap_pend <= 1'b1;
      if (sel_start) begin
        plane_sel <= 1'b1;
        plane1_q  <= cfg_plane1;
      end else if (state == S_NEXT && mode == M_SWAP) begin
        plane_sel <= ~plane_sel;
      end
    end
  end
`else
  assign swap_go   = 1'b0;
  assign swap_data = plane0_q;
`endif

  always_comb begin
    wr_off  = 8'h00;
    wr_data = 32'h0;
    case (mode)
      M_START: case (idx)
        3'd0:    begin wr_off = 8'h10; wr_data = {16'd0, width_q};  end
        3'd1:    begin wr_off = 8'h18; wr_data = {16'd0, height_q}; end
        3'd2:    begin wr_off = 8'h20; wr_data = stride_q;          end
        3'd3:    begin wr_off = 8'h28; wr_data = {26'd0, format_q}; end
        3'd4:    begin wr_off = 8'h30; wr_data = plane0_q;          end
        default: begin wr_off = 8'h00; wr_data = 32'h81;            end
      endcase
      M_SWAP:  begin wr_off = 8'h30; wr_data = swap_data; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    m_axi.awvalid = 1'b0;
    m_axi.wvalid  = 1'b0;
    m_axi.awaddr  = 32'h0;
    m_axi.wdata   = 32'h0;
    m_axi.wstrb   = 4'hF;
    m_axi.bready  = 1'b0;
    m_axi.arvalid = 1'b0;
    m_axi.araddr  = 32'h0;
    m_axi.rready  = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state)
      S_IDLE, S_FIN: begin
        busy = 1'b0;
        done = (state == S_FIN);
        if (sel_start)      state_nxt = S_WR;
        else if (sel_stop)  state_nxt = running ? S_WR : S_FIN;
        else if (sel_swap)  state_nxt = S_WR;
        else                state_nxt = S_IDLE;
      end
      S_WR: begin
        m_axi.awvalid = !aw_done;
        m_axi.wvalid  = !w_done;
        m_axi.awaddr  = BASE_ADDR + {24'd0, wr_off};
        m_axi.wdata   = wr_data;
        if (wr_leave) state_nxt = S_WB;
      end
      S_WB: begin
        m_axi.bready = 1'b1;
        if (m_axi.bvalid) state_nxt = (m_axi.bresp != 2'b00) ? S_IDLE : S_NEXT;
      end
      S_NEXT: begin
        case (mode)
          M_START: state_nxt = (idx == 3'd5) ? S_FIN : S_WR;
          M_STOP:  state_nxt = S_POLL_AR;
          default: state_nxt = S_IDLE;
        endcase
      end
      S_POLL_AR: begin
        m_axi.arvalid = 1'b1;
        m_axi.araddr  = BASE_ADDR;
        if (m_axi.arready) state_nxt = S_POLL_R;
      end
      S_POLL_R: begin
        m_axi.rready = 1'b1;
        if (m_axi.rvalid) state_nxt = S_POLL_CHK;
      end
      S_POLL_CHK: begin
        if (rd_err)                                  state_nxt = S_IDLE;
        else if (rd_idle)                            state_nxt = S_FIN;
        else if (poll_cnt >= PCW'(POLL_MAX))         state_nxt = S_IDLE;
        else                                         state_nxt = S_POLL_AR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode <= M_START; idx <= '0; aw_done <= 1'b0; w_done <= 1'b0;
      poll_cnt <= '0; rd_idle <= 1'b0; rd_err <= 1'b0;
      running <= 1'b0; err <= 1'b0; stop_pend <= 1'b0;
      width_q <= '0; height_q <= '0; stride_q <= '0; format_q <= '0; plane0_q <= '0;
    end else begin
      if (sel_start) begin
        mode      <= M_START;
        idx       <= '0;
        err       <= 1'b0;
        stop_pend <= stop_pend | stop;
        width_q   <= cfg_width;
        height_q  <= cfg_height;
        stride_q  <= (cfg_stride != 16'd0) ? {16'd0, cfg_stride} : {16'd0, cfg_width} * PB;
        format_q  <= cfg_format;
        plane0_q  <= cfg_plane0;
      end else if (sel_stop) begin
        mode      <= M_STOP;
        idx       <= '0;
        poll_cnt  <= '0;
        stop_pend <= 1'b0;
      end else if (sel_swap) begin
        mode <= M_SWAP;
        idx  <= '0;
      end else if (busy && stop && mode != M_STOP) begin
        stop_pend <= 1'b1;
      end
      if (state == S_WR) begin
        aw_done <= wr_leave ? 1'b0 : (aw_done | aw_hs);
        w_done  <= wr_leave ? 1'b0 : (w_done | w_hs);
      end
      if (state == S_WB && m_axi.bvalid && m_axi.bresp != 2'b00) begin
        err       <= 1'b1;
        stop_pend <= 1'b0;
      end
      if (state == S_NEXT) begin
        idx <= idx + 3'd1;
        if (mode == M_START && idx == 3'd5) running <= 1'b1;
      end
      if (state == S_POLL_R && m_axi.rvalid) begin
        rd_idle  <= m_axi.rdata[2];
        rd_err   <= (m_axi.rresp != 2'b00);
        poll_cnt <= poll_cnt + PCW'(1);
      end
      if (state == S_POLL_CHK) begin
        if (rd_err || (!rd_idle && poll_cnt >= PCW'(POLL_MAX))) begin
          err       <= 1'b1;
          stop_pend <= 1'b0;
        end else if (rd_idle) begin
          running <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_vfb_cfg_sequencer.sv
// Bench for vfb_cfg_sequencer: AXI-Lite slave model, write scoreboard, table-driven start/stop vectors.
module tb_vfb_cfg_sequencer;
  localparam logic [31:0] BASE = 32'h43C0_0000;

  logic clk, resetn, start, stop;
  logic [15:0] cfg_width, cfg_height, cfg_stride;
  logic [5:0]  cfg_format;
  logic [31:0] cfg_plane0;
  logic busy, running, done, err;
`ifdef VFB_SWAP_EN
  logic [31:0] cfg_plane1;
  logic        frame_irq;
`endif

  vfb_axil_if axi();

  vfb_cfg_sequencer #(.BASE_ADDR(BASE), .PIXEL_BYTES(4), .POLL_MAX(4)) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_stride(cfg_stride),
    .cfg_format(cfg_format), .cfg_plane0(cfg_plane0),
`ifdef VFB_SWAP_EN
    .cfg_plane1(cfg_plane1), .frame_irq(frame_irq),
`endif
    .busy(busy), .running(running), .done(done), .err(err), .m_axi(axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int aw_cnt, aw_dly, wr_num, err_at, rd_num, idle_after, aw_hs_cnt, w_hs_cnt;
  logic have_aw, have_w;
  logic [31:0] aw_a, w_d, cur_a, cur_d;
  logic aw_hs, w_hs, ar_hs;
  logic [63:0] exp_q[$], act_q[$];
  logic [63:0] act_w;

  assign axi.awready = axi.awvalid && (aw_cnt >= aw_dly);
  assign axi.wready  = axi.wvalid;
  assign axi.arready = axi.arvalid;
  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs  = axi.wvalid && axi.wready;
  assign ar_hs = axi.arvalid && axi.arready;
  assign cur_a = aw_hs ? axi.awaddr : aw_a;
  assign cur_d = w_hs ? axi.wdata : w_d;

  always @(posedge clk) begin
    if (!resetn) begin
      aw_cnt <= 0; wr_num <= 0; rd_num <= 0; aw_hs_cnt <= 0; w_hs_cnt <= 0;
      have_aw <= 1'b0; have_w <= 1'b0; aw_a <= '0; w_d <= '0;
      axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
      axi.rvalid <= 1'b0; axi.rdata <= '0; axi.rresp <= 2'b00;
    end else begin
      aw_cnt <= (axi.awvalid && !axi.awready) ? aw_cnt + 1 : 0;
      if (aw_hs) aw_hs_cnt <= aw_hs_cnt + 1;
      if (w_hs)  w_hs_cnt  <= w_hs_cnt + 1;
      if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
      if ((have_aw || aw_hs) && (have_w || w_hs)) begin
        axi.bvalid <= 1'b1;
        axi.bresp  <= (wr_num == err_at) ? 2'b10 : 2'b00;
        wr_num     <= wr_num + 1;
        act_q.push_back({cur_a, cur_d});
        have_aw <= 1'b0; have_w <= 1'b0;
      end else begin
        have_aw <= have_aw || aw_hs; have_w <= have_w || w_hs;
        aw_a <= cur_a; w_d <= cur_d;
      end
      if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
      if (ar_hs) begin
        axi.rvalid <= 1'b1;
        axi.rdata  <= (rd_num >= idle_after) ? 32'h4 : 32'h0;
        rd_num     <= rd_num + 1;
      end
    end
  end

  // Scoreboard: every completed write is matched against the expected queue.
  always @(negedge clk) begin
    while (act_q.size() > 0) begin
      act_w = act_q.pop_front();
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write act=%0h exp=none", act_w);
      end else begin
        chk("write", act_w, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  typedef struct {
    logic [15:0] w, h, s;
    logic [5:0]  f;
    logic [31:0] p0;
    logic [31:0] exp_stride;
  } vec_t;
  vec_t vecs[4];

  task automatic drive_cfg(input vec_t v);
    cfg_width = v.w; cfg_height = v.h; cfg_stride = v.s; cfg_format = v.f; cfg_plane0 = v.p0;
    exp_q.push_back({BASE + 32'h10, 16'd0, v.w});
    exp_q.push_back({BASE + 32'h18, 16'd0, v.h});
    exp_q.push_back({BASE + 32'h20, v.exp_stride});
    exp_q.push_back({BASE + 32'h28, 26'd0, v.f});
    exp_q.push_back({BASE + 32'h30, v.p0});
    exp_q.push_back({BASE + 32'h00, 32'h81});
  endtask

  task automatic pulse(input logic s, input logic p);
    start = s; stop = p;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    cfg_width = 16'hDEAD; cfg_height = 16'hBEEF; cfg_stride = 16'h1; cfg_plane0 = 32'hFFFF_FFFF;
  endtask

  task automatic wait_done(input string nm, input int maxc, output int cyc);
    cyc = 0;
    while (!done && cyc < maxc) begin cyc++; @(negedge clk); end
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s_timeout act=no_done exp=done", nm);
    end
  endtask

  task automatic wait_idle(input string nm, input int maxc, output bit saw_done);
    int cyc = 0;
    saw_done = 1'b0;
    while (busy && cyc < maxc) begin
      if (done) saw_done = 1'b1;
      cyc++; @(negedge clk);
    end
    if (done) saw_done = 1'b1;
    if (busy) begin
      checks++; failures++;
      $display("FAIL %s_timeout act=busy exp=idle", nm);
    end
  endtask

  task automatic do_stop(input string nm, input int reads_before_idle, input int exp_lat);
    int r0, cyc;
    idle_after = rd_num + reads_before_idle;
    r0 = rd_num;
    exp_q.push_back({BASE, 32'h0});
    pulse(1'b0, 1'b1);
    wait_done(nm, 200, cyc);
    chk({nm, "_lat"}, cyc, exp_lat);
    chk({nm, "_reads"}, rd_num - r0, reads_before_idle + 1);
    chk({nm, "_running"}, running, 0);
    chk({nm, "_err"}, err, 0);
  endtask

  initial begin
    int cyc, s0, w0;
    bit saw;
    vecs[0] = '{w:16'd640,   h:16'd480,  s:16'd0,    f:6'd20, p0:32'h0010_0000, exp_stride:32'd2560};
    vecs[1] = '{w:16'd1920,  h:16'd1080, s:16'd8000, f:6'd12, p0:32'h8000_0000, exp_stride:32'd8000};
    vecs[2] = '{w:16'hFFFF,  h:16'd1,    s:16'd0,    f:6'd63, p0:32'h0000_1000, exp_stride:32'h0003_FFFC};
    vecs[3] = '{w:16'd1,     h:16'hFFFF, s:16'hFFFF, f:6'd0,  p0:32'hFFFF_FFF0, exp_stride:32'h0000_FFFF};
    resetn = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_width = '0; cfg_height = '0; cfg_stride = '0; cfg_format = '0; cfg_plane0 = '0;
    aw_dly = 0; err_at = -1; idle_after = 0;
`ifdef VFB_SWAP_EN
    cfg_plane1 = 32'h0020_0000; frame_irq = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
    chk("rst_addr", {axi.awaddr, axi.araddr}, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Table: configure/start then a one-read stop for each vector.
    foreach (vecs[i]) begin
      drive_cfg(vecs[i]);
      pulse(1'b1, 1'b0);
      wait_done("start_vec", 200, cyc);
      chk("start_lat", cyc, 18);
      chk("start_running", running, 1);
      chk("start_busy", busy, 0);
      chk("start_drained", exp_q.size(), 0);
      @(negedge clk);
      do_stop("stop_vec", 0, 6);
    end

    // Stop while not running: done pulse only, no bus traffic.
    s0 = aw_hs_cnt;
    pulse(1'b0, 1'b1);
    wait_done("stop_norun", 20, cyc);
    chk("stop_norun_lat", cyc, 0);
    chk("stop_norun_aw", aw_hs_cnt - s0, 0);
    @(negedge clk);

    // Start and stop in the same cycle: start runs first, stop follows.
    drive_cfg(vecs[0]);
    exp_q.push_back({BASE, 32'h0});
    idle_after = rd_num;
    pulse(1'b1, 1'b1);
    wait_done("both_start", 200, cyc);
    chk("both_running1", running, 1);
    @(negedge clk);
    wait_done("both_stop", 200, cyc);
    chk("both_running0", running, 0);
    chk("both_drained", exp_q.size(), 0);
    @(negedge clk);

    // awready 5 cycles behind wready: W drops alone, AW held, no duplicates.
    aw_dly = 5; s0 = aw_hs_cnt; w0 = w_hs_cnt;
    drive_cfg(vecs[1]);
    pulse(1'b1, 1'b0);
    @(negedge clk);
    chk("awdly_w_dropped", axi.wvalid, 0);
    chk("awdly_aw_held", axi.awvalid, 1);
    chk("wstrb", axi.wstrb, 4'hF);
    wait_done("awdly", 400, cyc);
    chk("awdly_aw_cnt", aw_hs_cnt - s0, 6);
    chk("awdly_w_cnt", w_hs_cnt - w0, 6);
    aw_dly = 0;
    @(negedge clk);
    do_stop("stop_awdly", 0, 6);

    // SLVERR on the third write aborts the sequence.
    s0 = aw_hs_cnt;
    err_at = wr_num + 2;
    cfg_width = 16'd100; cfg_height = 16'd50; cfg_stride = 16'd0; cfg_format = 6'd1; cfg_plane0 = 32'h0;
    exp_q.push_back({BASE + 32'h10, 32'd100});
    exp_q.push_back({BASE + 32'h18, 32'd50});
    exp_q.push_back({BASE + 32'h20, 32'd400});
    pulse(1'b1, 1'b0);
    wait_idle("slverr", 100, saw);
    err_at = -1;
    repeat (10) @(negedge clk);
    chk("slverr_err", err, 1);
    chk("slverr_busy", busy, 0);
    chk("slverr_running", running, 0);
    chk("slverr_no_done", saw, 0);
    chk("slverr_aw_cnt", aw_hs_cnt - s0, 3);
    chk("slverr_drained", exp_q.size(), 0);

    // Next start clears err; stop sees busy twice, then idle.
    drive_cfg(vecs[0]);
    pulse(1'b1, 1'b0);
    wait_done("restart", 200, cyc);
    chk("restart_err_clr", err, 0);
    @(negedge clk);
`ifdef VFB_SWAP_EN
    exp_q.push_back({BASE + 32'h30, 32'h0020_0000});
    exp_q.push_back({BASE + 32'h30, 32'h0010_0000});
    exp_q.push_back({BASE + 32'h30, 32'h0020_0000});
    for (int k = 0; k < 3; k++) begin
      frame_irq = 1'b1; @(negedge clk);
      frame_irq = 1'b0; repeat (12) @(negedge clk);
    end
    chk("swap_drained", exp_q.size(), 0);
    chk("swap_running", running, 1);
`endif
    do_stop("stop_poll3", 2, 12);

    // Core never reports idle: exactly POLL_MAX reads, err, no done, running kept.
    drive_cfg(vecs[2]);
    pulse(1'b1, 1'b0);
    wait_done("pre_timeout", 200, cyc);
    @(negedge clk);
    idle_after = 32'h7FFF_FFFF;
    s0 = rd_num;
    exp_q.push_back({BASE, 32'h0});
    pulse(1'b0, 1'b1);
    wait_idle("poll_timeout", 200, saw);
    chk("timeout_reads", rd_num - s0, 4);
    chk("timeout_err", err, 1);
    chk("timeout_no_done", saw, 0);
    chk("timeout_running", running, 1);
    chk("timeout_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
